// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA state encoding, counter widths and default 640x480 offsets.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_LOCKED
    } state_e;

    localparam int H_CNT_W = 10;
    localparam int V_CNT_W = 10;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int ERR_W   = 16;
    localparam int MATCH_W = 3;

    localparam logic [H_CNT_W-1:0] H_CNT_MAX = '1;

    localparam int VGA_H_OFFSET    = 144;
    localparam int VGA_H_ACTIVE    = 640;
    localparam int VGA_V_OFFSET    = 35;
    localparam int VGA_V_ACTIVE    = 480;
    localparam int VGA_LOCK_FRAMES = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - strobe-qualified assertion-edge detector for an active-low sync.
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe_i,
    input  logic sync_n_i,
    output logic edge_o
);

    // History resets low so a sync already asserted out of reset is not an edge.
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else if (strobe_i) begin
            prev_q <= sync_n_i;
        end
    end

    assign edge_o = strobe_i & ~sync_n_i & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: geometry measurement, lock FSM, pixel coordinate recovery.
// Optional saturating error counter enabled by VGA_DECODE_ERRCNT_EN.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_OFFSET    = VGA_H_OFFSET,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_OFFSET    = VGA_V_OFFSET,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_strobe,
    input  logic               hsync_n,
    input  logic               vsync_n,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               active,
    output logic               locked,
    output logic [H_CNT_W-1:0] line_len,
    output logic [V_CNT_W-1:0] frame_lines,
    output logic               sync_error,
    output logic [ERR_W-1:0]   err_count
);

    localparam int H_END = H_OFFSET + H_ACTIVE;
    localparam int V_END = V_OFFSET + V_ACTIVE;
    localparam logic [H_CNT_W-1:0] H_LO = H_CNT_W'(H_OFFSET);
    localparam logic [H_CNT_W:0]   H_HI = (H_CNT_W+1)'(H_END);
    localparam logic [V_CNT_W-1:0] V_LO = V_CNT_W'(V_OFFSET);
    localparam logic [V_CNT_W:0]   V_HI = (V_CNT_W+1)'(V_END);

    logic h_edge, v_edge, h_timeout, err_event;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d, h_len_now;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d, frame_lines_q, frame_lines_d;
    logic [H_CNT_W-1:0] prev_len_q, prev_len_d, ref_len_q, ref_len_d;
    logic [V_CNT_W-1:0] prev_lines_q, prev_lines_d, ref_lines_q, ref_lines_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    state_e state_q, state_d;
    logic sync_error_q;
    logic h_in, v_in;

    vga_sync_edge u_h_edge (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (pixel_strobe),
        .sync_n_i (hsync_n),
        .edge_o   (h_edge)
    );

    vga_sync_edge u_v_edge (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (pixel_strobe),
        .sync_n_i (vsync_n),
        .edge_o   (v_edge)
    );

    assign h_len_now = h_cnt_q + H_CNT_W'(1);
    assign match_inc = match_q + MATCH_W'(1);

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_timeout     = 1'b0;
        if (pixel_strobe) begin
            if (h_edge) begin
                line_len_d = h_len_now;
                h_cnt_d    = '0;
                v_cnt_d    = v_cnt_q + V_CNT_W'(1);
            end else if (h_cnt_q == H_CNT_MAX) begin
                h_timeout = 1'b1;
            end else begin
                h_cnt_d = h_len_now;
            end
            // A vsync edge overrides the hsync increment on a shared strobe.
            if (v_edge) begin
                frame_lines_d = v_cnt_q;
                v_cnt_d       = '0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        prev_len_d   = prev_len_q;
        prev_lines_d = prev_lines_q;
        ref_len_d    = ref_len_q;
        ref_lines_d  = ref_lines_q;
        err_event    = 1'b0;
        if (v_edge) begin
            prev_len_d   = line_len_d;
            prev_lines_d = frame_lines_d;
        end
        case (state_q)
            ST_SEARCH: begin
                if (v_edge) begin
                    state_d = ST_TRACK;
                    match_d = '0;
                end
            end
            ST_TRACK: begin
                if (v_edge) begin
                    if (line_len_d == prev_len_q && frame_lines_d == prev_lines_q) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_FRAMES)) begin
                            state_d     = ST_LOCKED;
                            ref_len_d   = line_len_d;
                            ref_lines_d = frame_lines_d;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if ((h_edge && h_len_now != ref_len_q) || (v_edge && v_cnt_q != ref_lines_q)) begin
                    err_event = 1'b1;
                    state_d   = ST_TRACK;
                    match_d   = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        if (h_timeout) begin
            state_d   = ST_SEARCH;
            match_d   = '0;
            err_event = (state_q == ST_LOCKED);
        end
    end

    // Next-state values equal current ones on strobe-less cycles, so only sync_error moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            prev_len_q    <= '0;
            prev_lines_q  <= '0;
            ref_len_q     <= '0;
            ref_lines_q   <= '0;
            match_q       <= '0;
            state_q       <= ST_SEARCH;
            sync_error_q  <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            prev_len_q    <= prev_len_d;
            prev_lines_q  <= prev_lines_d;
            ref_len_q     <= ref_len_d;
            ref_lines_q   <= ref_lines_d;
            match_q       <= match_d;
            state_q       <= state_d;
            sync_error_q  <= err_event;
        end
    end

    assign h_in = (h_cnt_q >= H_LO) && ({1'b0, h_cnt_q} < H_HI);
    assign v_in = (v_cnt_q >= V_LO) && ({1'b0, v_cnt_q} < V_HI);

    assign locked      = (state_q == ST_LOCKED);
    assign active      = locked & h_in & v_in;
    assign x           = active ? X_W'(h_cnt_q - H_LO) : '0;
    assign y           = active ? Y_W'(v_cnt_q - V_LO) : '0;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign sync_error  = sync_error_q;

`ifdef VGA_DECODE_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (sync_error_q && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder using a reduced 40x12 frame geometry.
module tb_vga_sync_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixel_strobe;
    logic       hsync_n;
    logic       vsync_n;
    logic [9:0] x;
    logic [8:0] y;
    logic       active;
    logic       locked;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       sync_error;
    logic [15:0] err_count;

    vga_sync_decoder #(
        .H_OFFSET    (8),
        .H_ACTIVE    (20),
        .V_OFFSET    (2),
        .V_ACTIVE    (6),
        .LOCK_FRAMES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_strobe (pixel_strobe),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .x            (x),
        .y            (y),
        .active       (active),
        .locked       (locked),
        .line_len     (line_len),
        .frame_lines  (frame_lines),
        .sync_error   (sync_error),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

`ifdef VGA_DECODE_ERRCNT_EN
    localparam int ERRCNT_ON = 1;
`else
    localparam int ERRCNT_ON = 0;
`endif

    typedef struct {
        int nlines;
        int short_line;
        bit chk_lock;
        bit exp_locked;
        int exp_len;
        int exp_lines;
        int exp_errs;
    } frame_t;

    typedef struct {
        int frame;
        int v;
        int h;
        int ex;
        int ey;
        bit ea;
    } probe_t;

    localparam int NFRAMES = 16;
    localparam int NPROBES = 8;

    frame_t frames[NFRAMES];
    probe_t probes[NPROBES];

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (sync_error === 1'b1) err_seen = err_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_line_len"}, 32'(line_len), 0);
        check({tag, "_frame_lines"}, 32'(frame_lines), 0);
        check({tag, "_sync_error"}, 32'(sync_error), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    // One strobe cycle followed by a strobe-less cycle with inverted syncs that must be ignored.
    task automatic strobe(input logic hs, input logic vs);
        hsync_n      = hs;
        vsync_n      = vs;
        pixel_strobe = 1'b1;
        @(negedge clk);
        pixel_strobe = 1'b0;
        hsync_n      = ~hs;
        vsync_n      = ~vs;
        @(negedge clk);
    endtask

    function automatic logic hs_of(input int h);
        return !(h >= 2 && h <= 5);
    endfunction

    task automatic run_frame(input int idx);
        int len;
        int base;
        base = err_seen;
        for (int v = 0; v < frames[idx].nlines; v++) begin
            len = (v == frames[idx].short_line) ? 39 : 40;
            for (int h = 0; h < len; h++) begin
                strobe(hs_of(h), (v != 10));
                for (int p = 0; p < NPROBES; p++) begin
                    if (probes[p].frame == idx && probes[p].v == v && probes[p].h == h) begin
                        check($sformatf("f%0d_v%0d_h%0d_x", idx, v, h), 32'(x), probes[p].ex);
                        check($sformatf("f%0d_v%0d_h%0d_y", idx, v, h), 32'(y), probes[p].ey);
                        check($sformatf("f%0d_v%0d_h%0d_active", idx, v, h), 32'(active), 32'(probes[p].ea));
                    end
                end
            end
        end
        if (frames[idx].chk_lock)
            check($sformatf("frame%0d_locked", idx), 32'(locked), 32'(frames[idx].exp_locked));
        check($sformatf("frame%0d_line_len", idx), 32'(line_len), frames[idx].exp_len);
        check($sformatf("frame%0d_frame_lines", idx), 32'(frame_lines), frames[idx].exp_lines);
        check($sformatf("frame%0d_sync_errors", idx), err_seen - base, frames[idx].exp_errs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int base;
        frames[0]  = '{12, -1, 1'b1, 1'b0, 40, 10, 0};
        frames[1]  = '{12, -1, 1'b1, 1'b0, 40, 12, 0};
        frames[2]  = '{12, -1, 1'b1, 1'b0, 40, 12, 0};
        frames[3]  = '{12, -1, 1'b1, 1'b1, 40, 12, 0};
        frames[4]  = '{12,  5, 1'b1, 1'b0, 40, 12, 1};
        frames[5]  = '{12, -1, 1'b0, 1'b0, 40, 12, 0};
        frames[6]  = '{12, -1, 1'b1, 1'b1, 40, 12, 0};
        frames[7]  = '{13, -1, 1'b1, 1'b1, 40, 12, 0};
        frames[8]  = '{12, -1, 1'b1, 1'b0, 40, 13, 1};
        frames[9]  = '{12, -1, 1'b1, 1'b0, 40, 12, 0};
        frames[10] = '{12, -1, 1'b1, 1'b0, 40, 12, 0};
        frames[11] = '{12, -1, 1'b1, 1'b1, 40, 12, 0};
        frames[12] = '{12, -1, 1'b1, 1'b0, 40, 10, 0};
        frames[13] = '{12, -1, 1'b1, 1'b0, 40, 12, 0};
        frames[14] = '{12, -1, 1'b1, 1'b0, 40, 12, 0};
        frames[15] = '{12, -1, 1'b1, 1'b1, 40, 12, 0};

        probes[0] = '{2, 11, 10,  0, 0, 1'b0};
        probes[1] = '{3, 11,  9,  0, 0, 1'b0};
        probes[2] = '{3, 11, 10,  0, 0, 1'b1};
        probes[3] = '{3, 11, 29, 19, 0, 1'b1};
        probes[4] = '{3, 11, 30,  0, 0, 1'b0};
        probes[5] = '{7,  0, 20, 10, 1, 1'b1};
        probes[6] = '{7,  4, 15,  5, 5, 1'b1};
        probes[7] = '{7,  5, 15,  0, 0, 1'b0};

        reset        = 1'b1;
        pixel_strobe = 1'b0;
        hsync_n      = 1'b1;
        vsync_n      = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        for (int f = 0; f < 12; f++) run_frame(f);

        base = err_seen;
        for (int i = 0; i < 1100; i++) strobe(1'b1, 1'b1);
        check("timeout_sync_errors", err_seen - base, 1);
        check("timeout_locked", 32'(locked), 0);
        check("timeout_active", 32'(active), 0);
        check("timeout_x", 32'(x), 0);
        check("err_count_after_3", 32'(err_count), ERRCNT_ON ? 3 : 0);

        base = err_seen;
        for (int l = 0; l < 3; l++)
            for (int h = 0; h < 801; h++) strobe(!(h >= 16 && h <= 111), 1'b1);
        check("line801_line_len", 32'(line_len), 801);
        check("line801_frame_lines", 32'(frame_lines), 12);

        repeat (5) strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b0);
        check("both_edge_frame_lines", 32'(frame_lines), 5);
        check("both_edge_line_len", 32'(line_len), 790);
        repeat (3) strobe(1'b0, 1'b0);
        repeat (6) strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b1);
        check("after_both_line_len", 32'(line_len), 10);
        repeat (3) strobe(1'b1, 1'b1);
        strobe(1'b1, 1'b0);
        check("after_both_frame_lines", 32'(frame_lines), 1);
        check("search_track_sync_errors", err_seen - base, 0);

        for (int f = 12; f < NFRAMES; f++) run_frame(f);

        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 40; h++) strobe(hs_of(h), 1'b1);
        for (int h = 0; h < 4; h++) strobe(hs_of(h), 1'b1);
        check("pre_reset_locked", 32'(locked), 1);
        check("pre_reset_err_count", 32'(err_count), ERRCNT_ON ? 3 : 0);

        reset        = 1'b1;
        pixel_strobe = 1'b1;
        hsync_n      = 1'b0;
        vsync_n      = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        pixel_strobe = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) strobe(1'b0, 1'b0);
        check("held_low_line_len", 32'(line_len), 0);
        check("held_low_frame_lines", 32'(frame_lines), 0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        check("post_reset_line_len", 32'(line_len), 5);
        check("post_reset_frame_lines", 32'(frame_lines), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the 640x480 VGA timing generator: samples active-low `hsync_n`/`vsync_n` on `pixel_strobe` cycles, measures line and frame geometry, and locks after consecutive identical frames. Once locked it recovers pixel coordinates and the active-video flag. It is used as a monitor or capture front end and as a self-check for the display pipeline.

## Interface
- `H_OFFSET`, default 144: strobes from the hsync assertion edge to the first active pixel.
- `H_ACTIVE`, default 640: active pixels per line.
- `V_OFFSET`, default 35: line index of the first active line, counted from the vsync edge.
- `V_ACTIVE`, default 480: active lines per frame.
- `LOCK_FRAMES`, default 2: consecutive matching frames required to lock (1..7).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `pixel_strobe`  in  1  one-cycle pixel enable; all sampling and counting happens only on these cycles.
- `hsync_n`  in  1  horizontal sync, active-low.
- `vsync_n`  in  1  vertical sync, active-low.
- `x`  out  10  pixel column; 0 outside the active region.
- `y`  out  9  pixel row; 0 outside the active region.
- `active`  out  1  high when locked and inside the active window.
- `locked`  out  1  lock status.
- `line_len`  out  10  strobes per line, measured last.
- `frame_lines`  out  10  hsync edges per frame, measured last.
- `sync_error`  out  1  one-cycle pulse on loss of lock or timeout.
- `err_count`  out  16  saturating error count (see Configuration).

## Operation
- **Edge detect:** an assertion edge is a strobe sample with the input low while the previous strobe sample was high. The previous-sample registers reset to 0, so a sync already low out of reset produces no edge.
- **h_cnt (10b):**
  - On an hsync edge: `line_len` <= h_cnt+1, then h_cnt <= 0.
  - Otherwise h_cnt increments, saturating at 1023. Saturation is a timeout.
- **v_cnt (10b):**
  - On an hsync edge: v_cnt increments.
  - On a vsync edge: `frame_lines` <= v_cnt, then v_cnt <= 0.
  - If both edges fall on the same strobe, the vsync clear wins: v_cnt=0, and h_cnt still clears.
- **Active window:** H_OFFSET <= h_cnt < H_OFFSET+H_ACTIVE and V_OFFSET <= v_cnt < V_OFFSET+V_ACTIVE.
  - When locked, x = h_cnt-H_OFFSET and y = v_cnt-V_OFFSET, truncated to port width.
  - Outside the window, or when unlocked, x=0, y=0, active=0.
- **FSM:**
  - SEARCH: the first vsync edge moves to TRACK with match=0.
  - TRACK: at each vsync edge, compare the {line_len, frame_lines} pair against the pair from the previous frame.
    - Equal: match increments.
    - Different: match <= 0.
    - When match reaches LOCK_FRAMES, go to LOCKED and latch the reference pair.
  - LOCKED: any hsync edge with h_cnt+1 != reference line_len, or any vsync edge with v_cnt != reference frame_lines, pulses `sync_error` and moves to TRACK with match=0.
  - Any state: an h_cnt timeout moves to SEARCH, and pulses `sync_error` if the FSM was LOCKED.
- `locked` = (state==LOCKED).

## Timing
- Every register updates on the `clk` edge of a strobe cycle. `x`/`y`/`active` are valid on the cycle after the strobe that sampled the syncs and hold until the next strobe.
- `line_len`/`frame_lines` update one cycle after the edge strobe. `locked` rises one cycle after the LOCK_FRAMES-th matching vsync edge.
- `sync_error` is exactly one clk wide.
- Reset, including mid-frame: all outputs 0, counters 0, FSM in SEARCH, `err_count` 0.
- A strobe-less clk changes nothing.

## Configuration
- `VGA_DECODE_ERRCNT_EN` defined: `err_count` increments, saturating at 0xFFFF, on every `sync_error` pulse.
- Not defined: `err_count` is tied to 0 and no counter logic exists.

## Structure
- Package `vga_pkg` holds:
  - the FSM state enum (SEARCH, TRACK, LOCKED);
  - the counter width constants;
  - the default 640x480 offset constants shared with the generator.
- Sub-module `vga_sync_edge` is instantiated twice (h and v). It provides the strobe-qualified falling-edge detector with reset-low history.

## Test plan
- Drive generator-equivalent timing (801-strobe lines, hsync low at h=16..111, 525 lines) -> `line_len`=801, `locked` high one cycle after the 2nd matching vsync edge, first active pixel x=0/y=0.
- Locked, shorten one line to 800 strobes -> single-cycle `sync_error`, `locked`=0, relock after 2 clean frames.
- Hold `hsync_n` high for 1100 strobes -> timeout, FSM in SEARCH, `sync_error` pulse if previously locked, `active`=0.
- Hsync and vsync edges on the same strobe -> v_cnt=0 and h_cnt=0 on that edge; `frame_lines` captures the prior count.
- Assert `reset` mid-frame while locked -> next cycle all outputs 0; a sync held low through reset produces no edge.
- With `VGA_DECODE_ERRCNT_EN`: 3 injected errors -> `err_count`=3. Without the macro: `err_count`=0.
